// File: rtl/macro_array.sv
// macro_array: binary compute-in-memory macro. Holds one 1-bit weight row per
// output channel and computes XNOR-popcount dot products with the activation
// beat. Partial sums accumulate over 1..4 passes. The result is either raw or
// ADC-quantised, and it is held in an output register behind a valid/ready
// handshake.
module macro_array #(
    parameter int IN_CH     = 32,
    parameter int KSIZE     = 9,
    parameter int OUT_CH    = 64,
    parameter int O_DW      = 12,
    parameter int ADC_BITS  = 6,
    parameter int ADC_SHIFT = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          enable,
    input  logic                          adc,
    input  logic [1:0]                    chs_ps,
    input  logic                          wr_en,
    input  logic [$clog2(OUT_CH)-1:0]     wr_addr,
    input  logic [IN_CH*KSIZE-1:0]        wr_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IN_CH*KSIZE-1:0]        data_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_CH*O_DW-1:0]        data_out
);

    localparam int N  = IN_CH * KSIZE;
    localparam int AW = $clog2(OUT_CH);

    localparam logic signed [O_DW-1:0] QMAX = O_DW'((1 << (ADC_BITS - 1)) - 1);
    localparam logic signed [O_DW-1:0] QMIN = ~QMAX;

    // Weight store, one row per output channel.
    logic [N-1:0]           w_q [OUT_CH];

    // Accumulation and group state.
    logic signed [O_DW-1:0] acc_q [OUT_CH];
    logic signed [O_DW-1:0] acc_d [OUT_CH];
    logic [1:0]             pass_cnt_q, pass_cnt_d;
    logic [1:0]             ps_q, ps_d;
    logic                   adc_q, adc_d;

    // Output register.
    logic                   out_valid_q, out_valid_d;
    logic [OUT_CH*O_DW-1:0] data_out_q, data_out_d;

    logic                   accept;
    logic                   first;
    logic                   last;
    logic [1:0]             eff_ps;
    logic                   eff_adc;
    logic                   wr_ok;

    function automatic logic [O_DW-1:0] popcount(input logic [N-1:0] v);
        logic [O_DW-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            c = c + O_DW'(v[i]);
        end
        return c;
    endfunction

    // Floor shift followed by saturation to the signed ADC code range.
    function automatic logic signed [O_DW-1:0] quantise(input logic signed [O_DW-1:0] r);
        logic signed [O_DW-1:0] q;
        q = r >>> ADC_SHIFT;
        if (q > QMAX) begin
            q = QMAX;
        end else if (q < QMIN) begin
            q = QMIN;
        end
        return q;
    endfunction

    // The reset term keeps in_ready low throughout reset, whatever enable is.
    assign in_ready  = rstn && enable && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign wr_ok     = (32'(wr_addr) < 32'(OUT_CH));

    // The first beat of a group takes pass count and mode from the live
    // inputs. Later beats use the values latched on that first beat.
    assign first   = (pass_cnt_q == 2'd0);
    assign eff_ps  = first ? chs_ps : ps_q;
    assign eff_adc = first ? adc : adc_q;
    assign last    = (pass_cnt_q == eff_ps);

    // Next-state: accumulate the per-channel partial sums and load the output
    // register on the final beat of a group.
    always_comb begin
        logic signed [O_DW-1:0] psum;
        logic signed [O_DW-1:0] base;
        logic signed [O_DW-1:0] sum;

        acc_d       = acc_q;
        pass_cnt_d  = pass_cnt_q;
        ps_d        = ps_q;
        adc_d       = adc_q;
        out_valid_d = out_valid_q && !out_ready;
        data_out_d  = data_out_q;
        psum        = '0;
        base        = '0;
        sum         = '0;

        for (int unsigned j = 0; j < OUT_CH; j++) begin
            psum = signed'((popcount(~(data_in ^ w_q[j])) << 1) - O_DW'(N));
            base = first ? '0 : acc_q[j];
            sum  = base + psum;
            if (accept) begin
                if (last) begin
                    acc_d[j] = '0;
                    data_out_d[j*O_DW +: O_DW] = eff_adc ? quantise(sum) : sum;
                end else begin
                    acc_d[j] = sum;
                end
            end
        end

        if (accept) begin
            if (last) begin
                pass_cnt_d  = 2'd0;
                out_valid_d = 1'b1;
            end else begin
                pass_cnt_d = pass_cnt_q + 2'd1;
                if (first) begin
                    ps_d  = chs_ps;
                    adc_d = adc;
                end
            end
        end
    end

    // Compute and output state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned j = 0; j < OUT_CH; j++) begin
                acc_q[j] <= '0;
            end
            pass_cnt_q  <= '0;
            ps_q        <= '0;
            adc_q       <= 1'b0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            acc_q       <= acc_d;
            pass_cnt_q  <= pass_cnt_d;
            ps_q        <= ps_d;
            adc_q       <= adc_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
        end
    end

    // Weight rows. A write lands at the edge, so a beat accepted on the same
    // edge still sees the old row. Writes do not depend on enable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned r = 0; r < OUT_CH; r++) begin
                w_q[r] <= '0;
            end
        end else if (wr_en && wr_ok) begin
            w_q[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_macro_array.sv
// tb_macro_array: runs directed scenarios and then randomized stimulus on
// macro_array. Expected outputs come from an integer-arithmetic model kept in
// this bench.
module tb_macro_array;

    localparam int IN_CH     = 32;
    localparam int KSIZE     = 9;
    localparam int OUT_CH    = 64;
    localparam int O_DW      = 12;
    localparam int ADC_BITS  = 6;
    localparam int ADC_SHIFT = 4;
    localparam int N         = IN_CH * KSIZE;
    localparam int AW        = $clog2(OUT_CH);

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   enable;
    logic                   adc;
    logic [1:0]             chs_ps;
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [N-1:0]           wr_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [N-1:0]           data_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_CH*O_DW-1:0] data_out;

    int total = 0;
    int bad   = 0;

    macro_array #(
        .IN_CH(IN_CH), .KSIZE(KSIZE), .OUT_CH(OUT_CH),
        .O_DW(O_DW), .ADC_BITS(ADC_BITS), .ADC_SHIFT(ADC_SHIFT)
    ) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .adc(adc), .chs_ps(chs_ps),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
    );

    always #5 clk = ~clk;

    // Reference model: integer dot products and group bookkeeping.
    logic [N-1:0] wm [OUT_CH];
    int           macc [OUT_CH];
    int           mout [OUT_CH];
    int           mcnt;
    int           mpasses;
    bit           madc;
    bit           mv;

    function automatic int mq(input int r, input bit a);
        int q;
        if (!a) return r;
        q = r >>> ADC_SHIFT;
        if (q > (1 << (ADC_BITS - 1)) - 1) q = (1 << (ADC_BITS - 1)) - 1;
        if (q < -(1 << (ADC_BITS - 1)))    q = -(1 << (ADC_BITS - 1));
        return q;
    endfunction

    function automatic bit m_ready();
        return rstn && enable && (!mv || out_ready);
    endfunction

    always @(posedge clk or negedge rstn) begin
        bit rdy;
        if (!rstn) begin
            for (int j = 0; j < OUT_CH; j++) begin
                wm[j] = '0; macc[j] = 0; mout[j] = 0;
            end
            mcnt = 0; mpasses = 1; madc = 0; mv = 0;
        end else begin
            rdy = m_ready();
            if (mv && out_ready) mv = 0;
            if (in_valid && rdy) begin
                if (mcnt == 0) begin
                    mpasses = int'(chs_ps) + 1;
                    madc = adc;
                    for (int j = 0; j < OUT_CH; j++) macc[j] = 0;
                end
                for (int j = 0; j < OUT_CH; j++)
                    macc[j] += N - 2 * $countones(data_in ^ wm[j]);
                mcnt++;
                if (mcnt == mpasses) begin
                    for (int j = 0; j < OUT_CH; j++) mout[j] = mq(macc[j], madc);
                    mv = 1;
                    mcnt = 0;
                end
            end
            if (wr_en && int'(wr_addr) < OUT_CH) wm[wr_addr] = wr_data;
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    function automatic int dch(input int j);
        logic signed [O_DW-1:0] v;
        v = data_out[j*O_DW +: O_DW];
        return int'(v);
    endfunction

    // Cycle-by-cycle comparison of the DUT against the model, sampled between edges.
    always @(negedge clk) begin
        #1;
        chk("in_ready", int'(in_ready), int'(m_ready()));
        chk("out_valid", int'(out_valid), int'(mv));
        if (mv && out_valid) begin
            for (int j = 0; j < OUT_CH; j++)
                chk($sformatf("data_out[%0d]", j), dch(j), mout[j]);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Present one beat. The caller must make sure in_ready is high.
    task automatic send(input logic [N-1:0] d, input logic a, input logic [1:0] ps);
        in_valid = 1'b1; data_in = d; adc = a; chs_ps = ps;
        step();
        in_valid = 1'b0;
    endtask

    function automatic logic [N-1:0] rnd_vec();
        logic [N-1:0] v;
        logic [31:0]  r;
        int           m;
        r = '0;
        m = $urandom_range(0, 4);
        for (int i = 0; i < N; i++) begin
            if (i % 32 == 0) r = $urandom;
            v[i] = r[i % 32];
        end
        if (m == 1) v = '0;
        if (m == 2) v = '1;
        if (m == 3) v = wm[$urandom_range(0, OUT_CH - 1)] ^ (v & {N{r[0]}} & {N{r[1]}});
        return v;
    endfunction

    logic [N-1:0] ones;
    logic [N-1:0] zeros;

    initial begin
        ones = '1; zeros = '0;
        rstn = 1'b0; enable = 1'b1; adc = 1'b0; chs_ps = 2'd0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        in_valid = 1'b0; data_in = '0; out_ready = 1'b1;

        // Reset: in_ready must stay low even with enable high.
        step(); step(); #2;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_data0", dch(0), 0);
        chk("rst_data63", dch(OUT_CH - 1), 0);
        step();
        rstn = 1'b1;

        // A single raw beat with every bit matching gives +288.
        send(zeros, 1'b0, 2'd0); #2;
        chk("t1_valid", int'(out_valid), 1);
        chk("t1_ch0", dch(0), 288);
        chk("t1_ch63", dch(OUT_CH - 1), 288);
        chk("t1_model", mout[0], 288);

        // Every bit mismatching in ADC mode: -288 >>> 4 = -18.
        send(ones, 1'b1, 2'd0); #2;
        chk("t2_ch0", dch(0), -18);
        chk("t2_model", mout[7], -18);

        // Four passes: 1152 saturates to +31 in ADC mode and passes through in raw mode.
        send(zeros, 1'b1, 2'd3); send(zeros, 1'b1, 2'd3); send(zeros, 1'b1, 2'd3); #2;
        chk("t3_no_valid_early", int'(out_valid), 0);
        send(zeros, 1'b1, 2'd3); #2;
        chk("t3_adc_sat", dch(0), 31);
        for (int i = 0; i < 4; i++) send(zeros, 1'b0, 2'd3);
        #2;
        chk("t3_raw", dch(3), 1152);

        // A write on the same edge as a beat: that beat still uses the old row.
        wr_en = 1'b1; wr_addr = AW'(5); wr_data = ones;
        send(ones, 1'b0, 2'd0);
        wr_en = 1'b0; #2;
        chk("t4_old_row", dch(5), -288);
        chk("t4_other", dch(4), -288);
        send(ones, 1'b0, 2'd0); #2;
        chk("t4_new_row", dch(5), 288);
        chk("t4_other2", dch(4), -288);

        // Backpressure: the result holds, then drains while the next one loads.
        send(zeros, 1'b0, 2'd0);
        out_ready = 1'b0;
        in_valid = 1'b1; data_in = ones;
        step(); step(); step(); #2;
        chk("t5_ready_low", int'(in_ready), 0);
        chk("t5_hold", dch(0), 288);
        out_ready = 1'b1;
        send(ones, 1'b0, 2'd0); #2;
        chk("t5_valid_kept", int'(out_valid), 1);
        chk("t5_updated", dch(0), -288);
        chk("t5_updated5", dch(5), 288);

        // Dropping enable mid-group holds the partial sums.
        send(zeros, 1'b0, 2'd3); send(zeros, 1'b0, 2'd3);
        enable = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        in_valid = 1'b0; enable = 1'b1;
        send(zeros, 1'b0, 2'd3); send(zeros, 1'b0, 2'd3); #2;
        chk("t6_ch0", dch(0), 1152);
        chk("t6_ch5", dch(5), -1152);

        // A reset pulse mid-group discards the partial passes and clears the weights.
        send(ones, 1'b0, 2'd3); send(ones, 1'b0, 2'd3);
        rstn = 1'b0; step(); rstn = 1'b1;
        for (int i = 0; i < 4; i++) send(zeros, 1'b0, 2'd3);
        #2;
        chk("t7_ch0", dch(0), 1152);
        chk("t7_ch5", dch(5), 1152);

        // Randomized traffic, checked against the model on every cycle.
        for (int c = 0; c < 1500; c++) begin
            step();
            rstn      = ($urandom_range(0, 199) != 0);
            enable    = ($urandom_range(0, 9) != 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            adc       = 1'($urandom_range(0, 1));
            chs_ps    = 2'($urandom_range(0, 3));
            wr_en     = ($urandom_range(0, 9) == 0);
            wr_addr   = AW'($urandom_range(0, OUT_CH - 1));
            wr_data   = rnd_vec();
            data_in   = rnd_vec();
        end
        step();
        rstn = 1'b1; in_valid = 1'b0; wr_en = 1'b0;
        step(); step(); #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/macro_array.md
# macro_array

Parametrised behavioural model of the binary compute-in-memory macro: stores 1-bit weights for OUT_CH output channels and computes XNOR-popcount dot products over IN_CH×KSIZE binary activations. Partial sums accumulate over 1–4 passes selected by chs_ps, and an optional ADC mode quantises and saturates the result. Adds a valid/ready handshake, a weight-write port and sequential partial-sum accumulation; it sits between the layer's input line buffer and the output requantiser.

## Interface
Parameters:
- IN_CH, 32, input channels per pass
- KSIZE, 9, kernel taps per channel (3×3)
- OUT_CH, 64, output channels (weight rows)
- O_DW, 12, signed output width; must hold ±4·IN_CH·KSIZE in raw mode
- ADC_BITS, 6, signed ADC code width, ≤ O_DW
- ADC_SHIFT, 4, arithmetic right shift applied before ADC saturation

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- enable  in  1  macro enable; low holds all compute state
- adc  in  1  1 = ADC quantised output, 0 = raw accumulated sum
- chs_ps  in  2  number of accumulation passes minus 1 (0..3 → 1..4 passes)
- wr_en  in  1  weight row write strobe
- wr_addr  in  $clog2(OUT_CH)  weight row (output channel) index
- wr_data  in  IN_CH*KSIZE  weight row; bit c*KSIZE+k = channel c, tap k
- in_valid  in  1  activation beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- data_in  in  IN_CH*KSIZE  binary activations, same bit order as wr_data
- out_valid  out  1  data_out valid
- out_ready  in  1  downstream accepts data_out
- data_out  out  OUT_CH*O_DW  signed result; channel j at [j*O_DW +: O_DW]

## Operation
- Encoding: bit 1 = +1, bit 0 = −1. Per channel j: pop = count of bits where data_in XNOR w[j] = 1; psum = 2·pop − IN_CH·KSIZE (range ±288 at defaults).
- Weight store: OUT_CH rows × IN_CH·KSIZE bits, reset to all 0. wr_en writes row wr_addr at clock edge regardless of enable. Write at cycle T affects beats accepted at T+1 onward; a beat accepted in cycle T uses the old row. wr_addr ≥ OUT_CH ignored.
- Group: passes = chs_ps+1, latched on the first beat of a group (pass_cnt = 0); changes to chs_ps mid-group are ignored. adc is latched at the same time.
- Per accepted beat: acc_j ← (pass_cnt==0 ? 0 : acc_j) + psum_j; pass_cnt increments.
- Last beat of group (pass_cnt == passes−1): result_j = acc_j + psum_j is written to data_out, out_valid ← 1, pass_cnt ← 0, acc cleared.
- Raw mode (adc=0): data_out_j = result_j sign-extended to O_DW.
- ADC mode (adc=1): q = result_j >>> ADC_SHIFT (floor), saturated to [−2^(ADC_BITS−1), 2^(ADC_BITS−1)−1], sign-extended to O_DW.
- in_ready = enable && (!out_valid || out_ready). Non-final beats are accepted under the same rule.
- enable low: no beats accepted; acc, pass_cnt and output register hold; output handshake still completes if out_valid && out_ready.

## Timing
- Reset values: in_ready 0 while rstn low, out_valid 0, data_out 0, acc 0, pass_cnt 0, all weights 0.
- Latency: final beat accepted at edge T → out_valid high and data_out valid after edge T (one cycle).
- data_out and out_valid hold stable while out_valid && !out_ready.
- Simultaneous out_ready and final beat in the same cycle: old result drains and new result loads, so out_valid stays 1 (full throughput, one group per passes cycles).
- Reset mid-group: partial accumulation discarded; the next accepted beat starts a new group.
- Weights are never reset by anything other than rstn.

## Test plan
- Reset, weights 0, data_in all 0, adc=0, chs_ps=0, one beat → next cycle out_valid=1, every channel = +288.
- Same weights, data_in all 1, adc=1 → every channel = −288>>>4 = −18.
- chs_ps=3, four all-match beats, adc=1 → out_valid only after the 4th beat; raw sum 1152, output saturates to +31; with adc=0 the output is 1152.
- Write row 5 = all 1 in the same cycle as a beat of all 1 → that beat's ch5 = −288; the next beat's ch5 = +288; other channels are unaffected.
- Hold out_ready=0 with a result pending → in_ready=0, data_out stable; then out_ready=1 concurrently with a new final beat → out_valid stays 1 and data_out updates.
- enable=0 mid-group (after pass 2 of 4) for 5 cycles, then resume → result equals the uninterrupted case; rstn pulse mid-group → the next 4-beat group's result excludes the earlier passes.
